// File: rtl/rmc_pkg.sv
// Shared types and helpers for the row-vector x weight-matrix streaming MAC.
// Holds the job FSM state encoding, width helpers and the per-lane shift/saturate rule.
package rmc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_t;

  // Bits needed to index n distinct values (never less than 1).
  function automatic int bits_for(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Arithmetic right shift (floor), then optional clamp to a signed out_w range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                   input int unsigned shift,
                                                   input logic sat,
                                                   input int unsigned out_w);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat && (sh > hi)) return hi;
    if (sat && (sh < lo)) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/rmc_mac_lane.sv
// One output column: registered product, wrapping accumulator and a
// shift/saturate output register loaded once the accumulation has drained.
module rmc_mac_lane
  import rmc_pkg::*;
#(
  parameter int OP1_WIDTH = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SW        = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 prod_en,
  input  logic                 acc_en,
  input  logic                 load_out,
  input  logic [OP1_WIDTH-1:0] elem,
  input  logic [W_WIDTH-1:0]   weight,
  input  logic [SW-1:0]        shift,
  input  logic                 sat,
  output logic [OUT_WIDTH-1:0] result
);

  localparam int PW = OP1_WIDTH + W_WIDTH;

  logic signed [PW-1:0]        elem_ext;
  logic signed [PW-1:0]        weight_ext;
  logic signed [PW-1:0]        prod_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;

  assign elem_ext   = PW'($signed(elem));
  assign weight_ext = PW'($signed(weight));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg <= '0;
      acc_reg  <= '0;
      result   <= '0;
    end else if (clear) begin
      prod_reg <= '0;
      acc_reg  <= '0;
      result   <= '0;
    end else begin
      if (prod_en) prod_reg <= elem_ext * weight_ext;
      if (acc_en) acc_reg <= acc_reg + ACC_WIDTH'(prod_reg);
      if (load_out) result <= OUT_WIDTH'(shift_sat(64'(acc_reg), 32'(shift), sat, OUT_WIDTH));
    end
  end

endmodule

// File: rtl/row_mat_stream_mac.sv
// Streams a signed row vector against consecutive rows of a writable weight RAM
// and returns one scaled output row per job over valid/ready handshakes.
module row_mat_stream_mac
  import rmc_pkg::*;
#(
  parameter int K_MAX      = 16,
  parameter int N_COL      = 8,
  parameter int OP1_WIDTH  = 8,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int BRAM_DEPTH = 64,
  localparam int AW = bits_for(BRAM_DEPTH),
  localparam int KW = bits_for(K_MAX + 1),
  localparam int SW = bits_for(ACC_WIDTH)
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       START,
  input  logic [KW-1:0]              CFG_K,
  input  logic [AW-1:0]              CFG_BASE,
  input  logic [SW-1:0]              CFG_SHIFT,
  input  logic                       CFG_SAT,
  output logic                       BUSY,
  output logic                       DONE,
  input  logic                       WR_EN,
  input  logic [AW-1:0]              WR_ADDR,
  input  logic [N_COL*W_WIDTH-1:0]   WR_DATA,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [OP1_WIDTH-1:0]       IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [N_COL*OUT_WIDTH-1:0] OUT_DATA
);

  state_t                   state_reg, state_next;
  logic [KW-1:0]            k_reg, count_reg, k_clamped;
  logic [AW-1:0]            addr_reg, addr_next;
  logic [SW-1:0]            shift_reg;
  logic                     sat_reg;
  logic [OP1_WIDTH-1:0]     elem_reg;
  logic [N_COL*W_WIDTH-1:0] rd_data_reg;
  logic                     elem_valid_reg, prod_valid_reg;
  logic [1:0]               drain_reg;
  logic                     start_go, beat, last_beat, load_out;

  logic [N_COL*W_WIDTH-1:0] mem [BRAM_DEPTH];

  assign start_go  = START && (state_reg == IDLE);
  assign beat      = IN_VALID && (state_reg == RUN);
  assign last_beat = beat && (count_reg == k_reg - KW'(1));
  assign load_out  = (state_reg == DRAIN) && (drain_reg == 2'd2);
  assign k_clamped = (CFG_K > KW'(K_MAX)) ? KW'(K_MAX) : CFG_K;
  assign addr_next = (addr_reg == AW'(BRAM_DEPTH - 1)) ? '0 : addr_reg + AW'(1);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    BUSY       = (state_reg != IDLE);
    IN_READY   = (state_reg == RUN);
    OUT_VALID  = (state_reg == OUT);
    DONE       = 1'b0;
    case (state_reg)
      IDLE:    if (START) state_next = (CFG_K == '0) ? OUT : RUN;
      RUN:     if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_reg == 2'd2) state_next = OUT;
      OUT: begin
        if (OUT_READY) begin
          state_next = IDLE;
          DONE       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      k_reg          <= '0;
      count_reg      <= '0;
      addr_reg       <= '0;
      shift_reg      <= '0;
      sat_reg        <= 1'b0;
      elem_reg       <= '0;
      elem_valid_reg <= 1'b0;
      prod_valid_reg <= 1'b0;
      drain_reg      <= '0;
    end else begin
      elem_valid_reg <= beat;
      prod_valid_reg <= elem_valid_reg;
      drain_reg      <= (state_reg == DRAIN) ? drain_reg + 2'd1 : 2'd0;
      if (start_go) begin
        k_reg     <= k_clamped;
        shift_reg <= CFG_SHIFT;
        sat_reg   <= CFG_SAT;
        count_reg <= '0;
        addr_reg  <= CFG_BASE;
      end else if (beat) begin
        count_reg <= count_reg + KW'(1);
        addr_reg  <= addr_next;
        elem_reg  <= IN_DATA;
      end
    end
  end

  // Read-before-write: a same-cycle write to the row being read returns the old row.
  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
    if (beat) rd_data_reg <= mem[addr_reg];
  end

  generate
    for (genvar gi = 0; gi < N_COL; gi++) begin : g_lane
      rmc_mac_lane #(
        .OP1_WIDTH(OP1_WIDTH),
        .W_WIDTH  (W_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SW       (SW)
      ) u_lane (
        .clk     (CLK),
        .rst_n   (RSTN),
        .clear   (start_go),
        .prod_en (elem_valid_reg),
        .acc_en  (prod_valid_reg),
        .load_out(load_out),
        .elem    (elem_reg),
        .weight  (rd_data_reg[gi*W_WIDTH +: W_WIDTH]),
        .shift   (shift_reg),
        .sat     (sat_reg),
        .result  (OUT_DATA[gi*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate

endmodule
